pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher.sv | 147 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event requests into stretched output
// pulses measured in slow_clk ticks, with a low gap between consecutive
// pulses and a small saturating queue of events that arrived while busy.
// Optional feature: define PULSE_STRETCHER_OVERFLOW_EN to get a sticky
// overflow flag that records dropped events; otherwise overflow is tied low.
//
// slow_clk is a one-cycle tick enable sampled on regular_clk, never a clock.
// Only regular_clk clocks state.
module pulse_stretcher #(
  parameter int HIGH_TICKS = 4,  // ticks held high per event, 1..255
  parameter int GAP_TICKS  = 4   // ticks held low between events, 1..255
) (
  input  logic       regular_clk,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       event_pulse,
  output logic       output_signal,
  output logic       busy,
  output logic [2:0] pending_count,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [2:0] pend_q, pend_d;
  logic       out_q, out_d;
  logic [8:0] tick_inc;
  logic       inc;  // an event wants to join the pending queue this cycle
  logic       dec;  // a pending event starts its pulse this cycle

  assign tick_inc = {1'b0, tick_q} + 9'd1;

  // Next-state and tick counter: IDLE -> HIGH -> GAP -> (HIGH | IDLE)
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ticks are ignored here. An event starting straight from an empty
        // queue is never counted; a non-empty queue gives up one entry.
        if (event_pulse || (pend_q != 3'd0)) begin
          state_d = ST_HIGH;
          tick_d  = 8'd0;
          dec     = (pend_q != 3'd0);
          inc     = event_pulse && (pend_q != 3'd0);
        end
      end
      ST_HIGH: begin
        inc = event_pulse;
        if (slow_clk) begin
          if (tick_inc == 9'(HIGH_TICKS)) begin
            state_d = ST_GAP;
            tick_d  = 8'd0;
          end else begin
            tick_d = tick_inc[7:0];
          end
        end
      end
      ST_GAP: begin
        inc = event_pulse;
        if (slow_clk) begin
          if (tick_inc == 9'(GAP_TICKS)) begin
            tick_d = 8'd0;
            // A same-cycle event is queued and immediately consumed.
            if ((pend_q != 3'd0) || event_pulse) begin
              state_d = ST_HIGH;
              dec     = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_inc[7:0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = 8'd0;
      end
    endcase
  end

  // Pending counter: +1 per queued event (saturating at 7), -1 per start
  always_comb begin
    pend_d = pend_q;
    if (inc && !dec) begin
      if (pend_q != 3'd7) begin
        pend_d = pend_q + 3'd1;
      end
    end else if (dec && !inc && (pend_q != 3'd0)) begin
      pend_d = pend_q - 3'd1;
    end
  end

  // Output level is registered from the next state, so no input reaches the pin
  always_comb begin
    out_d = (state_d == ST_HIGH);
  end

  // State registers; reset aborts any pulse and empties the queue
  always_ff @(posedge regular_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= 8'd0;
      pend_q  <= 3'd0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign output_signal = out_q;
  assign busy          = (state_q != ST_IDLE);
  assign pending_count = pend_q;

`ifdef PULSE_STRETCHER_OVERFLOW_EN
  logic ovf_q;
  logic drop;

  assign drop = inc && !dec && (pend_q == 3'd7);

  // Sticky record of any dropped event, cleared only by reset
  always_ff @(posedge regular_clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: two instances (4/4 and 1/1 ticks) share inputs
// and are compared every cycle against a tick-countdown reference model.
module tb_pulse_stretcher;

  localparam int M_IDLE = 0;
  localparam int M_HIGH = 1;
  localparam int M_GAP  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic slow_clk;
  logic event_pulse;
  always #5 clk = ~clk;

  logic       out_a, busy_a, ovf_a;
  logic [2:0] pend_a;
  logic       out_b, busy_b, ovf_b;
  logic [2:0] pend_b;

  pulse_stretcher #(.HIGH_TICKS(4), .GAP_TICKS(4)) dut_a (
    .regular_clk  (clk),
    .reset        (rst),
    .slow_clk     (slow_clk),
    .event_pulse  (event_pulse),
    .output_signal(out_a),
    .busy         (busy_a),
    .pending_count(pend_a),
    .overflow     (ovf_a)
  );

  pulse_stretcher #(.HIGH_TICKS(1), .GAP_TICKS(1)) dut_b (
    .regular_clk  (clk),
    .reset        (rst),
    .slow_clk     (slow_clk),
    .event_pulse  (event_pulse),
    .output_signal(out_b),
    .busy         (busy_b),
    .pending_count(pend_b),
    .overflow     (ovf_b)
  );

  // ---------------- scoreboard counters ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance is a mode plus "ticks left" countdown and an integer queue
  // length; queue arithmetic is plain add/subtract then clamp.
  int h_cfg[2] = '{4, 1};
  int g_cfg[2] = '{4, 1};
  int m_mode[2], m_left[2], m_pend[2], m_ovf[2], m_pulses[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE;
      m_left[k] = 0;
      m_pend[k] = 0;
      m_ovf[k]  = 0;
    end
  endfunction

  function automatic void model_step(input bit ev, input bit tk);
    for (int k = 0; k < 2; k++) begin
      int add;
      int take;
      int p;
      add  = 0;
      take = 0;
      case (m_mode[k])
        M_IDLE: begin
          if (ev || m_pend[k] > 0) begin
            if (m_pend[k] > 0) begin
              take = 1;
              add  = ev ? 1 : 0;
            end
            m_mode[k] = M_HIGH;
            m_left[k] = h_cfg[k];
            m_pulses[k]++;
          end
        end
        M_HIGH: begin
          add = ev ? 1 : 0;
          if (tk) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_mode[k] = M_GAP;
              m_left[k] = g_cfg[k];
            end
          end
        end
        default: begin
          add = ev ? 1 : 0;
          if (tk) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              if (m_pend[k] > 0 || ev) begin
                m_mode[k] = M_HIGH;
                m_left[k] = h_cfg[k];
                take = 1;
                m_pulses[k]++;
              end else begin
                m_mode[k] = M_IDLE;
              end
            end
          end
        end
      endcase
      p = m_pend[k] + add - take;
      if (p > 7) begin
        p = 7;
        m_ovf[k] = 1;
      end
      if (p < 0) p = 0;
      m_pend[k] = p;
    end
  endfunction

  function automatic int exp_ovf(input int k);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    return m_ovf[k];
`else
    return 0 * k;
`endif
  endfunction

  task automatic compare_all();
    check("out_a",  out_a,  m_mode[0] == M_HIGH);
    check("busy_a", busy_a, m_mode[0] != M_IDLE);
    check("pend_a", pend_a, m_pend[0]);
    check("ovf_a",  ovf_a,  exp_ovf(0));
    check("out_b",  out_b,  m_mode[1] == M_HIGH);
    check("busy_b", busy_b, m_mode[1] != M_IDLE);
    check("pend_b", pend_b, m_pend[1]);
    check("ovf_b",  ovf_b,  exp_ovf(1));
  endtask

  // ---------------- driver ----------------
  int tick_mode = 0;  // 0: every 10 cycles, 1: random, 2: every cycle
  int tcnt      = 0;
  int pulses_a  = 0;
  int pulses_b  = 0;
  bit prev_a    = 0;
  bit prev_b    = 0;
  int max_pend_a = 0;
  int consec_b  = 0;

  // One clock cycle: drive inputs, clock, update model, check outputs.
  task automatic step(input bit ev);
    bit tk;
    if (tick_mode == 0) begin
      tk   = (tcnt == 9);
      tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    end else if (tick_mode == 1) begin
      tk = ($urandom_range(0, 3) == 0);
    end else begin
      tk = 1'b1;
    end
    slow_clk    = tk;
    event_pulse = ev;
    @(posedge clk);
    model_step(ev, tk);
    #1;
    compare_all();
    if (out_a && !prev_a) pulses_a++;
    if (out_b && !prev_b) pulses_b++;
    if (out_b && prev_b) consec_b++;
    prev_a = out_a;
    prev_b = out_b;
    if (int'(pend_a) > max_pend_a) max_pend_a = int'(pend_a);
    slow_clk    = 1'b0;
    event_pulse = 1'b0;
  endtask

  task automatic run_to_idle(input int max_cycles);
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < max_cycles) begin
      step(1'b0);
      n++;
    end
    check("idle_reached", busy_a | busy_b, 0);
  endtask

  task automatic clear_counts();
    pulses_a   = 0;
    pulses_b   = 0;
    max_pend_a = 0;
    consec_b   = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit fired;
    rst = 1'b1;
    slow_clk = 1'b0;
    event_pulse = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) m_pulses[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    repeat (4) step(1'b0);

    // Single event from IDLE
    clear_counts();
    step(1'b1);
    check("single_first_high", out_a, 1);
    run_to_idle(200);
    check("single_pulses_a", pulses_a, 1);
    check("single_max_pend_a", max_pend_a, 0);

    // Three events one cycle apart during HIGH
    clear_counts();
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      step(1'b1);
    end
    check("three_pend_a", pend_a, 3);
    run_to_idle(800);
    check("three_pulses_a", pulses_a, 4);
    check("three_end_pend_a", pend_a, 0);

    // Nine events during HIGH: saturate the queue
    clear_counts();
    step(1'b1);
    repeat (9) step(1'b1);
    check("sat_pend_a", pend_a, 7);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    check("sat_ovf_a", ovf_a, 1);
`else
    check("sat_ovf_a", ovf_a, 0);
`endif
    run_to_idle(1500);
    check("sat_pulses_a", pulses_a, 8);

    // Event on the same cycle as GAP->HIGH with two pending
    clear_counts();
    step(1'b1);
    repeat (3) step(1'b1);
    fired = 1'b0;
    for (int i = 0; i < 800 && !fired; i++) begin
      if (m_mode[0] == M_GAP && m_left[0] == 1 && tcnt == 9 && m_pend[0] == 2) begin
        step(1'b1);
        fired = 1'b1;
        check("same_cycle_pend_a", pend_a, 2);
        check("same_cycle_high_a", out_a, 1);
      end else begin
        step(1'b0);
      end
    end
    check("same_cycle_reached", fired, 1);
    run_to_idle(1000);

    // Asynchronous reset mid-HIGH with three pending
    clear_counts();
    step(1'b1);
    repeat (3) step(1'b1);
    repeat (5) step(1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_out_a", out_a, 0);
    check("async_busy_a", busy_a, 0);
    check("async_pend_a", pend_a, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    clear_counts();
    repeat (150) step(1'b0);
    check("post_reset_pulses_a", pulses_a, 0);
    check("post_reset_pulses_b", pulses_b, 0);

    // Event in the first cycle after reset release
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    step(1'b1);
    check("first_cycle_event_a", out_a, 1);
    check("first_cycle_event_b", out_b, 1);
    run_to_idle(300);

    // Back-to-back events, 1/1 instance with a tick every cycle
    tick_mode = 2;
    clear_counts();
    for (int k = 0; k < 2; k++) m_pulses[k] = 0;
    repeat (40) step(1'b1);
    run_to_idle(1500);
    check("b2b_consec_high_b", consec_b, 0);
    check("b2b_pulses_b", pulses_b, m_pulses[1]);
    check("b2b_pulses_a", pulses_a, m_pulses[0]);

    // Randomized traffic with random tick spacing
    tick_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0);
    end
    run_to_idle(2000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
